// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/subtract computed one 4-bit ripple
// slice per clock, LS nibble first, with the carry chained across cycles.
// Handshake: start (sampled in IDLE) -> busy during RUN -> one-cycle done.

// One 4-bit ripple-carry slice; c3 is exposed for signed-overflow detection.
module nibble_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c3,
  output logic       c4
);
  logic [4:0] c;

  assign c[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign c3 = c[3];
  assign c4 = c[4];
endmodule

module nibble_serial_addsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  // Latched operands, nibble-addressable; b is already inverted for subtract.
  typedef struct packed {
    logic [NIB-1:0][3:0] a;
    logic [NIB-1:0][3:0] b;
  } oper_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nx;
  oper_t               op;
  logic                cy;
  logic [IW-1:0]       idx;
  logic [NIB-1:0][3:0] work, work_nx;
  logic [3:0]          s;
  logic                c3, c4;
  logic                last;

  nibble_slice u_slice (
    .a   (op.a[idx]),
    .b   (op.b[idx]),
    .cin (cy),
    .s   (s),
    .c3  (c3),
    .c4  (c4)
  );

  assign last = (idx == IW'(NIB - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Working result with the current slice merged in; feeds both the working
  // register and the final result load on the last nibble.
  always_comb begin
    work_nx      = work;
    work_nx[idx] = s;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: DONE always falls back to IDLE, so start there is dropped.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, step one slice per RUN cycle, and
  // publish sum/flags only on the final slice so partials never leak out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= '0;
      cy       <= 1'b0;
      idx      <= '0;
      work     <= '0;
      sum      <= '0;
      carryout <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op.a <= a;
            op.b <= sub ? ~b : b;
            cy   <= sub;
            idx  <= '0;
          end
        end
        RUN: begin
          work <= work_nx;
          cy   <= c4;
          if (last) begin
            sum      <= work_nx;
            carryout <= c4;
            ovf      <= c4 ^ c3;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/nibble_serial_addsub.md
Name: nibble_serial_addsub

Overview:
- Multi-cycle add/subtract sequencer for WIDTH-bit operands.
- Processes one 4-bit ripple-carry slice per clock, least-significant nibble first, and chains the carry between cycles.
- Gives the lab datapath wide arithmetic using a single 4-bit adder slice.
- Uses a start/busy/done handshake toward the issuing logic, such as a switch/button front end or a test controller.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB (derived, not overridable), WIDTH/4, number of slice cycles per operation.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high. Clears all state and outputs immediately.
- start  input  1  request a new operation; sampled only in IDLE.
- sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a result is loaded.
- sum  output  WIDTH  result of last completed operation.
- carryout  output  1  carry out of MSB of last result (for sub: 1 = no borrow, a>=b unsigned).
- ovf  output  1  two's-complement overflow of last result.

Behaviour:
- Reset (async, any state): state=IDLE, nibble index=0, working registers=0, busy=0, done=0, sum=0, carryout=0, ovf=0. An operation in flight is discarded with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: latch A=a, B=(sub ? ~b : b), carry=sub, index=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), at each edge:
  - Slice k=index: s = A[4k+3:4k] + B[4k+3:4k] + carry, ripple per bit.
  - Write s into the working result nibble k; carry <= c4 of the slice.
  - If k==NIB-1: load sum<=working result including this nibble, carryout<=c4, ovf<=c4^c3 of this slice; go to DONE.
  - Otherwise: index<=k+1.
- DONE:
  - done=1, busy=0 for exactly one cycle; next edge returns to IDLE unconditionally.
- Latency: the accepting edge is edge 0. NIB edges process nibbles 0..NIB-1. State becomes DONE, and sum/carryout/ovf update, after edge NIB. done is high from edge NIB to edge NIB+1.
- Minimum issue interval is NIB+2 cycles.
- start in RUN or DONE is ignored; no queuing. start held high continuously re-issues on each IDLE cycle with the operands present at that edge.
- a, b, sub may change freely after the accepting edge; the block uses only the latched copies.
- sum/carryout/ovf change only at the RUN->DONE transition (or reset). They hold the previous result throughout a new RUN; partial results are never visible on the outputs.
- Arithmetic is modulo 2^WIDTH. No saturation.
- WIDTH=4 (NIB=1): a single RUN cycle; the behaviour above still applies.

Test Plan (WIDTH=16):
- Add: a=0x1234, b=0x4321, sub=0, start pulse → busy 4 cycles; done pulse after edge 4; sum=0x5555, carryout=0, ovf=0; outputs stable after done.
- Signed overflow / unsigned wrap:
  - 0x7FFF+0x0001 → sum=0x8000, carryout=0, ovf=1.
  - 0xFFFF+0x0001 → sum=0x0000, carryout=1, ovf=0; confirms carry ripples across all 4 nibble cycles.
- Subtract:
  - 0x0005-0x0007 → sum=0xFFFE, carryout=0, ovf=0.
  - 0x8000-0x0001 → sum=0x7FFF, carryout=1, ovf=1.
- Ignore during busy: issue 0x0001+0x0001, then pulse start with a=0xAAAA, b=0x5555 in RUN cycle 2 and again in DONE → single done; sum=0x0002. A next start in IDLE yields 0xFFFF.
- Async reset mid-RUN: assert rst between edges in RUN cycle 2 → busy, done, sum, carryout, ovf go to 0 without waiting for a clock; no done pulse. After release, 0x00FF+0x0001 → sum=0x0100.
- Back-to-back: start held high for 20 cycles with constant operands → done pulses every 6 cycles, identical results each time.
